// File: rtl/pc_sequencer.sv
// PC sequencer: fetch request -> fetch response -> execute -> commit, with PC/retire tracking.
// Optional misaligned-target halt is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [31:0]      fetch_addr,
  input  logic             rsp_valid,
  input  logic [31:0]      rsp_inst,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             commit,
  input  logic             trap,
  input  logic [31:0]      trap_pc,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic             redirect,
`ifdef PC_MISALIGN_CHECK_EN
  output logic             misalign,
`endif
  output logic [CNT_W-1:0] retire_cnt
);

`ifdef PC_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_EXEC, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_EXEC} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [31:0]       pc_r;
  logic [31:0]       inst_r;
  logic              redirect_r;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [31:0]       next_pc_s;
  logic              fetch_valid_s;
  logic              inst_valid_s;
  logic              retire_s;
  logic              misaligned_s;
`ifdef PC_MISALIGN_CHECK_EN
  logic              misalign_r;
`endif

  // Next-PC selection, next-state decode and state-derived strobes
  always_comb begin
    state_s       = state_r;
    fetch_valid_s = 1'b0;
    inst_valid_s  = 1'b0;
    retire_s      = 1'b0;
    if (trap) begin
      next_pc_s = trap_pc;
    end else if (br_taken) begin
      next_pc_s = br_target;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
`ifdef PC_MISALIGN_CHECK_EN
    misaligned_s = (next_pc_s[1:0] != 2'b00);
`else
    misaligned_s = 1'b0;
`endif
    case (state_r)
      ST_REQ: begin
        fetch_valid_s = 1'b1;
        if (fetch_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_EXEC: begin
        inst_valid_s = 1'b1;
        if (commit) begin
          retire_s = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
          if (misaligned_s) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_REQ;
          end
`else
          state_s = ST_REQ;
`endif
        end else begin
          state_s = ST_EXEC;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      ST_HALT: begin
        state_s = ST_HALT;
      end
`endif
      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // Architectural state: PC, latched instruction, redirect pulse, retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      redirect_r   <= 1'b0;
      retire_cnt_r <= {CNT_W{1'b0}};
`ifdef PC_MISALIGN_CHECK_EN
      misalign_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      if (state_r == ST_WAIT && rsp_valid) begin
        inst_r <= rsp_inst;
      end
      if (retire_s) begin
        retire_cnt_r <= retire_cnt_r + CNT_ONE;
        // A misaligned target leaves the PC untouched, so it is not a redirect
        if (misaligned_s) begin
          redirect_r <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
          misalign_r <= 1'b1;
`endif
        end else begin
          pc_r       <= next_pc_s;
          redirect_r <= trap | br_taken;
        end
      end else begin
        redirect_r <= 1'b0;
      end
    end
  end

  // Valid strobes are forced low combinationally while reset is asserted
  assign fetch_valid = fetch_valid_s & rst_n;
  assign inst_valid  = inst_valid_s & rst_n;
  assign fetch_addr  = pc_r;
  assign pc          = pc_r;
  assign inst        = inst_r;
  assign redirect    = redirect_r;
  assign retire_cnt  = retire_cnt_r;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign    = misalign_r;
`endif

endmodule
